// File: rtl/multicycle_ctrl_v2.sv
// Purpose: second-generation multi-cycle ARM controller FSM with NZCV flag file, condition codes and sticky fault.
// Latency: DP 4, LDR 5, STR 4, B/BL 3, BX 3, cond-fail 2 cycles at zero wait; each not-ready cycle adds 1.
// Backpressure: Fetch/MemRead/MemWr hold on mem_ready=0; WAIT_MAX consecutive stalls send the FSM to Fault.
module multicycle_ctrl_v2 #(
  parameter bit COND_FULL = 1'b1,
  parameter int WAIT_MAX  = 15,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic        Shift_ctrl,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  BL_ctrl,
  output logic [3:0]  ALUControl,
  output logic        mem_req,
  output logic [3:0]  flags,
  output logic        fault,
  output logic [3:0]  fsm_state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_BX      = 4'd11,
    S_FAULT   = 4'd12
  } state_t;

  // Last count value before the stall that trips the timeout.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic [1:0] op;
  logic [3:0] dp_opc;
  logic       rd_is_pc;
  logic       is_bx;
  logic       arith_opc;
  logic       cond_pass;
  logic       timeout;
  logic       pcw_c, rw_c, mw_c, irw_c, req_c;
  logic       unused_instr;

  assign op        = Instr[27:26];
  assign dp_opc    = Instr[24:21];
  assign rd_is_pc  = (Instr[15:12] == 4'hF);
  assign is_bx     = (Instr[27:4] == 24'h12FFF1);
  // SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN produce meaningful carry/overflow.
  assign arith_opc = ((dp_opc >= 4'h2) && (dp_opc <= 4'h7)) || (dp_opc == 4'hA) || (dp_opc == 4'hB);
  assign timeout   = req_c && !mem_ready && (cnt_q == WAIT_LAST);
  assign unused_instr = ^Instr[3:0];

  // Evaluate the ARM condition field against the registered NZCV flags.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_pass = 1'b0;
    case (Instr[31:28])
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
    // The reduced decoder only honours EQ, NE and AL.
    if (!COND_FULL && !(Instr[31:28] == 4'h0 || Instr[31:28] == 4'h1 || Instr[31:28] == 4'hE)) begin
      cond_pass = 1'b0;
    end
  end

  // Datapath control vector: baseline first, then per-state overrides.
  always_comb begin
    pcw_c      = 1'b0;
    rw_c       = 1'b0;
    mw_c       = 1'b0;
    irw_c      = 1'b0;
    req_c      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b1;
    Shift_ctrl = 1'b0;
    ALUSrcB    = 2'b10;
    ResultSrc  = 2'b10;
    ALUControl = 4'b0100;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    BL_ctrl    = 2'b00;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        irw_c = mem_ready;
        pcw_c = mem_ready;
      end
      S_DECODE: begin
        if (op == 2'b10) RegSrc = 2'b01;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = dp_opc;
      end
      S_EXEC_I: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b11;
        Shift_ctrl = 1'b1;
        ALUControl = dp_opc;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        // TST/TEQ/CMP/CMN only set flags.
        rw_c      = (Instr[24:23] != 2'b10);
        pcw_c     = (Instr[24:23] != 2'b10) && rd_is_pc;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b0;
        ALUSrcB = Instr[25] ? 2'b11 : 2'b01;
        ImmSrc  = 2'b01;
        RegSrc  = 2'b10;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        req_c     = 1'b1;
        ResultSrc = 2'b00;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_c      = 1'b1;
        pcw_c     = rd_is_pc;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        req_c  = 1'b1;
        RegSrc = 2'b10;
        mw_c   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        RegSrc  = 2'b01;
        pcw_c   = 1'b1;
        if (Instr[24]) begin
          rw_c    = 1'b1;
          BL_ctrl = 2'b11;
        end
      end
      S_BX: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b1101;
        pcw_c      = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes and the memory request are suppressed while reset is held.
  assign PCWrite  = pcw_c & reset;
  assign RegWrite = rw_c  & reset;
  assign MemWrite = mw_c  & reset;
  assign IRWrite  = irw_c & reset;
  assign mem_req  = req_c & reset;

  // Next-state selection; a mem_ready in the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (!cond_pass)            state_d = S_FETCH;
        else if (is_bx)            state_d = S_BX;
        else if (op == 2'b00)      state_d = Instr[25] ? S_EXEC_I : S_EXEC_R;
        else if (op == 2'b01)      state_d = S_MEMADR;
        else if (op == 2'b10)      state_d = S_BRANCH;
        else                       state_d = S_FAULT;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:            state_d = S_FETCH;
      S_MEMADR:           state_d = Instr[20] ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FAULT;
      end
      S_MEMWB:            state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_BRANCH, S_BX:     state_d = S_FETCH;
      S_FAULT:            state_d = S_FAULT;
      default:            state_d = S_FAULT;
    endcase
  end

  // Flag file, wait counter and sticky fault next values.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == S_EXEC_R || state_q == S_EXEC_I) && Instr[20]) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (arith_opc) flags_d[1:0] = ALUFlags[1:0];
    end

    if (mem_ready || (state_d != state_q)) cnt_d = '0;
    else if (req_c)                        cnt_d = cnt_q + 1'b1;
    else                                   cnt_d = cnt_q;

    fault_d = fault_q | (state_d == S_FAULT);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign flags     = flags_q;
  assign fault     = fault_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Purpose: directed scoreboard bench for multicycle_ctrl_v2 (WAIT_MAX=4).
// Latency: expectation pushed just after each rising edge, compared on the following falling edge.
// Backpressure: mem_ready stalls are scripted per cycle in the stimulus.
module tb_multicycle_ctrl_v2;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, rw, mw, irw, req, adr, srca, shift;
    logic [1:0] srcb, res, imm, regsrc, bl;
    logic [3:0] alu;
    logic [3:0] flg;
    logic       flt;
  } obs_t;

  localparam logic [31:0] I_ADD   = 32'hE0810002;
  localparam logic [31:0] I_ADDS  = 32'hE0910002;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_MOVS  = 32'hE3B00000;
  localparam logic [31:0] I_SUBS  = 32'hE0510002;
  localparam logic [31:0] I_ANDS  = 32'hE0110002;
  localparam logic [31:0] I_BGE   = 32'hAA000000;
  localparam logic [31:0] I_BLT   = 32'hBA000000;
  localparam logic [31:0] I_BNV   = 32'hFA000000;
  localparam logic [31:0] I_CMP   = 32'hE1510002;
  localparam logic [31:0] I_LDR   = 32'hE5910004;
  localparam logic [31:0] I_STR   = 32'hE5810004;
  localparam logic [31:0] I_BL    = 32'hEB000010;
  localparam logic [31:0] I_BX    = 32'hE12FFF1E;
  localparam logic [31:0] I_MOVPC = 32'hE1A0F000;
  localparam logic [31:0] I_OP11  = 32'hEC000000;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, Shift_ctrl;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, BL_ctrl;
  logic [3:0]  ALUControl;
  logic        mem_req;
  logic [3:0]  flags;
  logic        fault;
  logic [3:0]  fsm_state;

  obs_t  exp_q[$];
  string tag_q[$];
  obs_t  e;
  string tag;
  int    checks;
  int    failures;

  multicycle_ctrl_v2 #(.COND_FULL(1'b1), .WAIT_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .Shift_ctrl(Shift_ctrl),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .BL_ctrl(BL_ctrl),
    .ALUControl(ALUControl), .mem_req(mem_req), .flags(flags), .fault(fault), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baseline control vector with the given state and flag values.
  function automatic obs_t base(input logic [3:0] st, input logic [3:0] flg);
    obs_t o;
    o      = '0;
    o.st   = st;
    o.srca = 1'b1;
    o.srcb = 2'b10;
    o.res  = 2'b10;
    o.alu  = 4'b0100;
    o.flg  = flg;
    return o;
  endfunction

  // Apply one cycle of stimulus and queue the expected outputs for it.
  task automatic drive(input logic [31:0] ins, input logic [3:0] af, input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    reset     = rst;
    Instr     = ins;
    ALUFlags  = af;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [3:0] flg);
    e = base(4'd0, flg); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    drive(ins, 4'h0, 1'b1, 1'b1);
  endtask

  task automatic dec(input logic [31:0] ins, input logic [3:0] flg, input logic [1:0] rs);
    e = base(4'd1, flg); e.regsrc = rs;
    drive(ins, 4'h0, 1'b1, 1'b1);
  endtask

  task automatic memadr(input logic [31:0] ins, input logic [3:0] flg);
    e = base(4'd2, flg); e.srca = 1'b0; e.srcb = 2'b01; e.imm = 2'b01; e.regsrc = 2'b10;
    drive(ins, 4'h0, 1'b1, 1'b1);
  endtask

  task automatic branch(input logic [31:0] ins, input logic [3:0] flg, input logic link);
    e = base(4'd9, flg); e.srca = 1'b0; e.srcb = 2'b01; e.imm = 2'b10; e.regsrc = 2'b01; e.pcw = 1'b1;
    if (link) begin e.rw = 1'b1; e.bl = 2'b11; end
    drive(ins, 4'h0, 1'b1, 1'b1);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    obs_t  got;
    obs_t  want;
    string t;
    if (exp_q.size() > 0) begin
      got = '{st: fsm_state, pcw: PCWrite, rw: RegWrite, mw: MemWrite, irw: IRWrite, req: mem_req,
              adr: AdrSrc, srca: ALUSrcA, shift: Shift_ctrl, srcb: ALUSrcB, res: ResultSrc,
              imm: ImmSrc, regsrc: RegSrc, bl: BL_ctrl, alu: ALUControl, flg: flags, flt: fault};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s (check %0d): got st=%0d vec=%h flags=%b fault=%b, required st=%0d vec=%h flags=%b fault=%b",
                 t, checks, got.st, got, got.flg, got.flt, want.st, want, want.flg, want.flt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; Instr = I_ADD; ALUFlags = 4'h0; mem_ready = 1'b1;

    tag = "reset_hold";
    e = base(4'd0, 4'h0);
    drive(I_ADD, 4'h0, 1'b1, 1'b0);
    drive(I_ADD, 4'h0, 1'b1, 1'b0);

    // ADD r0,r1,r2: S=0 so ALUFlags must not reach the flag file.
    tag = "add";
    fetch(I_ADD, 4'h0);
    dec(I_ADD, 4'h0, 2'b00);
    e = base(4'd6, 4'h0); e.srca = 1'b0; e.srcb = 2'b00; e.alu = 4'b0100;
    drive(I_ADD, 4'hF, 1'b1, 1'b1);
    e = base(4'd8, 4'h0); e.res = 2'b00; e.rw = 1'b1;
    drive(I_ADD, 4'h0, 1'b1, 1'b1);

    tag = "adds";
    fetch(I_ADDS, 4'h0);
    dec(I_ADDS, 4'h0, 2'b00);
    e = base(4'd6, 4'h0); e.srca = 1'b0; e.srcb = 2'b00; e.alu = 4'b0100;
    drive(I_ADDS, 4'b0100, 1'b1, 1'b1);
    e = base(4'd8, 4'b0100); e.res = 2'b00; e.rw = 1'b1;
    drive(I_ADDS, 4'h0, 1'b1, 1'b1);

    tag = "beq_taken";
    fetch(I_BEQ, 4'b0100);
    dec(I_BEQ, 4'b0100, 2'b01);
    branch(I_BEQ, 4'b0100, 1'b0);

    // MOVS is logical: N,Z loaded, C,V held.
    tag = "movs_imm";
    fetch(I_MOVS, 4'b0100);
    dec(I_MOVS, 4'b0100, 2'b00);
    e = base(4'd7, 4'b0100); e.srca = 1'b0; e.srcb = 2'b11; e.shift = 1'b1; e.alu = 4'b1101;
    drive(I_MOVS, 4'b0000, 1'b1, 1'b1);
    e = base(4'd8, 4'b0000); e.res = 2'b00; e.rw = 1'b1;
    drive(I_MOVS, 4'h0, 1'b1, 1'b1);

    tag = "beq_fail";
    fetch(I_BEQ, 4'b0000);
    dec(I_BEQ, 4'b0000, 2'b01);

    tag = "subs";
    fetch(I_SUBS, 4'b0000);
    dec(I_SUBS, 4'b0000, 2'b00);
    e = base(4'd6, 4'b0000); e.srca = 1'b0; e.srcb = 2'b00; e.alu = 4'b0010;
    drive(I_SUBS, 4'b0011, 1'b1, 1'b1);
    e = base(4'd8, 4'b0011); e.res = 2'b00; e.rw = 1'b1;
    drive(I_SUBS, 4'h0, 1'b1, 1'b1);

    tag = "ands_keep_cv";
    fetch(I_ANDS, 4'b0011);
    dec(I_ANDS, 4'b0011, 2'b00);
    e = base(4'd6, 4'b0011); e.srca = 1'b0; e.srcb = 2'b00; e.alu = 4'b0000;
    drive(I_ANDS, 4'b1000, 1'b1, 1'b1);
    e = base(4'd8, 4'b1011); e.res = 2'b00; e.rw = 1'b1;
    drive(I_ANDS, 4'h0, 1'b1, 1'b1);

    // flags=1011: N==V so GE passes and LT fails; NV never passes.
    tag = "bge_taken";
    fetch(I_BGE, 4'b1011);
    dec(I_BGE, 4'b1011, 2'b01);
    branch(I_BGE, 4'b1011, 1'b0);
    tag = "blt_fail";
    fetch(I_BLT, 4'b1011);
    dec(I_BLT, 4'b1011, 2'b01);
    tag = "cond_nv_fail";
    fetch(I_BNV, 4'b1011);
    dec(I_BNV, 4'b1011, 2'b01);

    tag = "cmp_no_wb";
    fetch(I_CMP, 4'b1011);
    dec(I_CMP, 4'b1011, 2'b00);
    e = base(4'd6, 4'b1011); e.srca = 1'b0; e.srcb = 2'b00; e.alu = 4'b1010;
    drive(I_CMP, 4'b0010, 1'b1, 1'b1);
    e = base(4'd8, 4'b0010); e.res = 2'b00;
    drive(I_CMP, 4'h0, 1'b1, 1'b1);

    // LDR: one stalled fetch, then three stalled MemRead cycles (one below the timeout).
    tag = "ldr_wait";
    e = base(4'd0, 4'b0010); e.req = 1'b1;
    drive(I_LDR, 4'h0, 1'b0, 1'b1);
    fetch(I_LDR, 4'b0010);
    dec(I_LDR, 4'b0010, 2'b00);
    memadr(I_LDR, 4'b0010);
    e = base(4'd3, 4'b0010); e.adr = 1'b1; e.req = 1'b1; e.res = 2'b00;
    for (int i = 0; i < 3; i++) drive(I_LDR, 4'h0, 1'b0, 1'b1);
    drive(I_LDR, 4'h0, 1'b1, 1'b1);
    e = base(4'd4, 4'b0010); e.res = 2'b01; e.rw = 1'b1;
    drive(I_LDR, 4'h0, 1'b1, 1'b1);

    tag = "bl";
    fetch(I_BL, 4'b0010);
    dec(I_BL, 4'b0010, 2'b01);
    branch(I_BL, 4'b0010, 1'b1);

    tag = "bx";
    fetch(I_BX, 4'b0010);
    dec(I_BX, 4'b0010, 2'b00);
    e = base(4'd11, 4'b0010); e.srca = 1'b0; e.srcb = 2'b00; e.alu = 4'b1101; e.pcw = 1'b1;
    drive(I_BX, 4'h0, 1'b1, 1'b1);

    tag = "mov_pc";
    fetch(I_MOVPC, 4'b0010);
    dec(I_MOVPC, 4'b0010, 2'b00);
    e = base(4'd6, 4'b0010); e.srca = 1'b0; e.srcb = 2'b00; e.alu = 4'b1101;
    drive(I_MOVPC, 4'h0, 1'b1, 1'b1);
    e = base(4'd8, 4'b0010); e.res = 2'b00; e.rw = 1'b1; e.pcw = 1'b1;
    drive(I_MOVPC, 4'h0, 1'b1, 1'b1);

    // STR never acknowledged: four stalled MemWr cycles, then sticky Fault.
    tag = "str_timeout";
    fetch(I_STR, 4'b0010);
    dec(I_STR, 4'b0010, 2'b00);
    memadr(I_STR, 4'b0010);
    e = base(4'd5, 4'b0010); e.adr = 1'b1; e.req = 1'b1; e.regsrc = 2'b10; e.mw = 1'b1;
    for (int i = 0; i < 4; i++) drive(I_STR, 4'h0, 1'b0, 1'b1);
    tag = "fault_sticky";
    e = base(4'd12, 4'b0010); e.flt = 1'b1;
    for (int i = 0; i < 3; i++) drive(I_STR, 4'h0, 1'b1, 1'b1);

    tag = "fault_reset";
    e = base(4'd0, 4'h0);
    drive(I_OP11, 4'h0, 1'b1, 1'b0);

    tag = "op11_fault";
    fetch(I_OP11, 4'h0);
    dec(I_OP11, 4'h0, 2'b00);
    e = base(4'd12, 4'h0); e.flt = 1'b1;
    drive(I_OP11, 4'h0, 1'b1, 1'b1);
    drive(I_OP11, 4'h0, 1'b1, 1'b1);

    tag = "reset_mid_access";
    e = base(4'd0, 4'h0);
    drive(I_LDR, 4'h0, 1'b1, 1'b0);
    fetch(I_LDR, 4'h0);
    dec(I_LDR, 4'h0, 2'b00);
    memadr(I_LDR, 4'h0);
    e = base(4'd3, 4'h0); e.adr = 1'b1; e.req = 1'b1; e.res = 2'b00;
    drive(I_LDR, 4'h0, 1'b0, 1'b1);
    e = base(4'd0, 4'h0);
    drive(I_LDR, 4'h0, 1'b0, 1'b0);
    tag = "refetch";
    fetch(I_ADD, 4'h0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_v2.md
# multicycle_ctrl_v2

Second-generation controller FSM for the multi-cycle ARM datapath. It adds the following over the first generation:
- full ARM condition-code evaluation against an internal registered NZCV flag file;
- a variable-latency memory handshake with a timeout counter;
- separate register and immediate execute states, plus an ALU write-back state;
- a sticky fault state for undefined opcodes and memory timeouts.

It sits between the instruction register/ALU and the datapath muxes and write enables, in place of the first-generation controller.

## Interface
Parameters:
- COND_FULL, 1, 1: all 15 ARM conditions decoded; 0: only EQ, NE, AL (others fail)
- WAIT_MAX, 15, max consecutive not-ready cycles per memory access before fault (1..255)
- CNT_W, 8, wait counter width; must satisfy 2^CNT_W > WAIT_MAX

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- Instr  in  32  current instruction register contents
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- mem_ready  in  1  memory completes the access requested this cycle
- PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, Shift_ctrl  out  1 each  datapath controls
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, BL_ctrl  out  2 each  datapath mux selects
- ALUControl  out  4  ALU opcode (ARM data-processing encoding)
- mem_req  out  1  memory access request
- flags  out  4  registered {N,Z,C,V}
- fault  out  1  sticky fault indicator
- fsm_state  out  4  current state encoding

## Operation
**State encodings:** Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWr=5, ExecuteR=6, ExecuteI=7, ALUWB=8, Branch=9, BX=11, Fault=12.

**Baseline output vector.** Every state drives this, then applies only its listed changes:
- all 1-bit outputs = 0;
- ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=0100 (ADD);
- ImmSrc=00, RegSrc=00, BL_ctrl=00, mem_req=0.

**Per-state behaviour:**
- Fetch:
  - changes: mem_req=1; IRWrite=PCWrite=mem_ready.
  - next: Decode when mem_ready, else stay in Fetch.
- Decode:
  - changes: RegSrc=01 when Op=10.
  - condition evaluation uses the `flags` register, not ALUFlags. EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL follow standard ARM semantics. Cond=1111 always fails.
  - condition fail: next=Fetch.
  - condition pass, by instruction:
    - Instr[27:4]=0x12FFF1: next=BX.
    - Op=00 with Instr[25]=0: next=ExecuteR.
    - Op=00 with Instr[25]=1: next=ExecuteI.
    - Op=01: next=MemAdr.
    - Op=10: next=Branch.
    - Op=11: next=Fault.
- ExecuteR:
  - changes: ALUSrcA=0, ALUSrcB=00, ALUControl=Instr[24:21].
  - next: ALUWB.
- ExecuteI:
  - changes: ALUSrcA=0, ALUSrcB=11, Shift_ctrl=1, ALUControl=Instr[24:21].
  - next: ALUWB.
- Flag update (both execute states), when Instr[20]=1 at the end of the execute cycle:
  - N and Z are always loaded from ALUFlags.
  - C and V are loaded only for arithmetic opcodes (0010–0111, 1010, 1011). They are held for logical and move opcodes.
- ALUWB:
  - changes: ResultSrc=00. RegWrite=1 unless Instr[24:23]=10 (TST/TEQ/CMP/CMN). PCWrite=RegWrite & (Rd==4'hF).
  - next: Fetch.
- MemAdr:
  - changes: ALUSrcA=0, ALUSrcB = Instr[25] ? 11 : 01, ImmSrc=01, RegSrc=10.
  - next: MemRead when Instr[20]=1, else MemWr.
- MemRead:
  - changes: AdrSrc=1, mem_req=1, ResultSrc=00.
  - next: MemWB when mem_ready, else stay.
- MemWB:
  - changes: ResultSrc=01, RegWrite=1, PCWrite=(Rd==4'hF).
  - next: Fetch.
- MemWr:
  - changes: AdrSrc=1, mem_req=1, RegSrc=10, MemWrite=1 (held until ready).
  - next: Fetch when mem_ready, else stay.
- Branch:
  - changes: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, RegSrc=01, PCWrite=1. When Instr[24]=1 (BL): RegWrite=1, BL_ctrl=11.
  - next: Fetch.
- BX:
  - changes: ALUSrcA=0, ALUSrcB=00, ALUControl=1101, PCWrite=1.
  - next: Fetch.
- Fault:
  - changes: none beyond the baseline vector; fault=1.
  - next: stays in Fault until reset.

**Wait counter:**
- increments each cycle with mem_req=1 and mem_ready=0.
- clears on mem_ready and on every state change.
- on reaching WAIT_MAX with mem_ready=0: next=Fault. A mem_ready in that same cycle wins.

## Timing
- **Reset** (reset=0, asynchronous): state=Fetch, flags=0000, counter=0, fault=0. All write strobes and mem_req are forced to 0 while reset=0. First fetch request occurs in the first cycle after deassertion.
- **Output timing:** outputs are combinational from state, Instr, and mem_ready. `flags`, `fault` and `fsm_state` are registered.
- **Zero-wait latencies (cycles):**
  - data-processing: 4 (F, D, E, WB);
  - LDR: 5;
  - STR: 4;
  - B/BL: 3;
  - BX: 3;
  - condition-fail: 2.
- Each not-ready cycle adds 1 cycle of latency.
- Flags written by an instruction are visible to the next instruction's Decode.
- Reset asserted mid-access drops mem_req in the same cycle.

## Test plan
- **Reset:** release reset, Instr=0xE0810002 (ADD r0,r1,r2), mem_ready=1 -> fsm_state 0,1,6,8,0. RegWrite=1 only in ALUWB. flags stay 0000.
- **Condition codes:** ADDS yielding ALUFlags=0100, then BEQ 0x0A000002 -> Branch taken, PCWrite=1. With flags=0000 the same BEQ goes Decode->Fetch in 2 cycles.
- **Flag preservation:** SUBS with ALUFlags=0011 -> flags=0011. Then ANDS with ALUFlags=1000 -> flags=1011 (C,V preserved).
- **Memory wait:** LDR 0xE5910004 with mem_ready low for 3 cycles in MemRead -> MemRead held 4 cycles, mem_req=1 throughout, RegWrite=1 only in MemWB.
- **Memory timeout:** WAIT_MAX=4, STR with mem_ready held low -> Fault after 4 wait cycles, fault=1, MemWrite=0 thereafter. Fault is cleared only by reset.
- **BL, BX, PC write:** BL 0xEB000010 -> RegWrite=1, BL_ctrl=11. BX 0xE12FFF1E -> state 11, ALUControl=1101. MOV pc,r0 -> PCWrite=1 in ALUWB. Op=11 -> Fault.
